// File: rtl/vid_sched_pkg.sv
// Shared constants for the video frame-buffer burst scheduler: job tags, FSM encoding and
// default memory map / line geometry.
package vid_sched_pkg;

    localparam logic [1:0] TAG_GBWR  = 2'd0;
    localparam logic [1:0] TAG_BLEND = 2'd1;
    localparam logic [1:0] TAG_OSD   = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } sched_state_e;

    localparam logic [22:0] DEF_FB_BASE0    = 23'h10000;
    localparam logic [22:0] DEF_FB_BASE1    = 23'h40000;
    localparam logic [22:0] DEF_OSD_BASE    = 23'h70000;
    localparam int unsigned DEF_LINE_STRIDE = 320;
    localparam int unsigned DEF_LINE_LEN    = 160;
    localparam int unsigned DEF_NUM_LINES   = 144;

endpackage

// File: rtl/vid_sched_prio_enc.sv
// Fixed-priority job picker: pending[0] (GB write) beats pending[1] (blend) beats pending[2] (OSD).
module vid_sched_prio_enc
    import vid_sched_pkg::*;
(
    input  logic [2:0] pending,
    output logic [2:0] grant,
    output logic [1:0] tag,
    output logic       any
);

    always_comb begin
        grant = 3'b000;
        tag   = TAG_GBWR;
        any   = |pending;
        if (pending[0]) begin
            grant = 3'b001;
            tag   = TAG_GBWR;
        end else if (pending[1]) begin
            grant = 3'b010;
            tag   = TAG_BLEND;
        end else if (pending[2]) begin
            grant = 3'b100;
            tag   = TAG_OSD;
        end
    end

endmodule

// File: rtl/vid_fb_burst_sched.sv
// PSRAM burst scheduler for GB line flush, blend prefetch and OSD prefetch with bank swapping.
// Optional VID_SCHED_STATS_EN adds busy_cycles / max_wait statistics outputs.
module vid_fb_burst_sched
    import vid_sched_pkg::*;
#(
    parameter logic [22:0] FB_BASE0    = DEF_FB_BASE0,
    parameter logic [22:0] FB_BASE1    = DEF_FB_BASE1,
    parameter logic [22:0] OSD_BASE    = DEF_OSD_BASE,
    parameter int unsigned LINE_STRIDE = DEF_LINE_STRIDE,
    parameter int unsigned LINE_LEN    = DEF_LINE_LEN,
    parameter int unsigned NUM_LINES   = DEF_NUM_LINES
) (
    input  logic        hClk,
    input  logic        reset,
    input  logic        hGBNewLine,
    input  logic        hVsync,
    input  logic        blend_en,
    input  logic        osd_en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [22:0] cmd_addr,
    output logic [8:0]  cmd_len,
    output logic [1:0]  cmd_tag,
    input  logic        cmd_done,
    output logic        wr_bank,
    output logic        busy,
`ifdef VID_SCHED_STATS_EN
    output logic [19:0] busy_cycles,
    output logic [7:0]  max_wait,
`endif
    output logic [7:0]  overrun_cnt
);

    localparam logic [22:0] STRIDE = 23'(LINE_STRIDE);
    localparam logic [8:0]  LEN    = 9'(LINE_LEN);
    localparam logic [7:0]  NLINES = 8'(NUM_LINES);

    sched_state_e state_q, state_d;
    logic [2:0]  pending_q, pending_d, grant_q, grant_d, sel_grant, clr_mask, pend_left;
    logic [7:0]  line_q, line_d, overrun_q, overrun_d;
    logic [22:0] line_off_q, line_off_d, sel_addr;
    logic [22:0] wr_addr_q, wr_addr_d, blend_addr_q, blend_addr_d, osd_addr_q, osd_addr_d;
    logic [22:0] cmd_addr_q, cmd_addr_d;
    logic [1:0]  cmd_tag_q, cmd_tag_d, sel_tag;
    logic        wr_bank_q, wr_bank_d, vsync_q, stale_q, stale_d, sel_any;
    logic        cmd_valid_q, cmd_valid_d, cmd_write_q, cmd_write_d;
    logic        frame_start, line_evt, new_req, hs;

    function automatic logic [22:0] bank_base(input logic bank);
        return bank ? FB_BASE1 : FB_BASE0;
    endfunction

    vid_sched_prio_enc u_prio (
        .pending (pending_q),
        .grant   (sel_grant),
        .tag     (sel_tag),
        .any     (sel_any)
    );

    assign frame_start = hVsync & ~vsync_q;
    assign line_evt    = hGBNewLine & ~hVsync & (line_q < NLINES);
    assign new_req     = frame_start | line_evt;
    assign hs          = (state_q == StIssue) & cmd_ready;
    // A request that replaced the pending set while a job was selected owns that bit now.
    assign clr_mask    = (hs && !stale_q) ? grant_q : 3'b000;
    assign pend_left   = pending_q & ~clr_mask;

    always_comb begin
        unique case (sel_grant)
            3'b010:  sel_addr = blend_addr_q;
            3'b100:  sel_addr = osd_addr_q;
            default: sel_addr = wr_addr_q;
        endcase
    end

    always_comb begin
        pending_d    = pend_left;
        line_d       = line_q;
        line_off_d   = line_off_q;
        wr_bank_d    = wr_bank_q;
        overrun_d    = overrun_q;
        wr_addr_d    = wr_addr_q;
        blend_addr_d = blend_addr_q;
        osd_addr_d   = osd_addr_q;
        if (frame_start) begin
            wr_bank_d    = ~wr_bank_q;
            line_d       = '0;
            line_off_d   = '0;
            pending_d    = {osd_en, blend_en, 1'b0};
            blend_addr_d = bank_base(wr_bank_q);
            osd_addr_d   = OSD_BASE;
        end else if (line_evt) begin
            if (|pend_left && overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
            pending_d[0]   = 1'b1;
            pending_d[2:1] = ((line_q + 8'd1) < NLINES) ? {osd_en, blend_en} : 2'b00;
            wr_addr_d      = bank_base(wr_bank_q) + line_off_q;
            blend_addr_d   = bank_base(~wr_bank_q) + line_off_q + STRIDE;
            osd_addr_d     = OSD_BASE + line_off_q + STRIDE;
            line_d         = line_q + 8'd1;
            line_off_d     = line_off_q + STRIDE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_tag_d   = cmd_tag_q;
        grant_d     = grant_q;
        stale_d     = stale_q;
        unique case (state_q)
            StIdle: begin
                if (sel_any) begin
                    cmd_valid_d = 1'b1;
                    cmd_write_d = (sel_tag == TAG_GBWR);
                    cmd_addr_d  = sel_addr;
                    cmd_tag_d   = sel_tag;
                    grant_d     = sel_grant;
                    stale_d     = new_req;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = StWait;
                end else if (new_req) begin
                    stale_d = 1'b1;
                end
            end
            StWait: begin
                if (cmd_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hClk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            line_q       <= '0;
            line_off_q   <= '0;
            wr_bank_q    <= 1'b0;
            vsync_q      <= 1'b0;
            overrun_q    <= '0;
            wr_addr_q    <= '0;
            blend_addr_q <= '0;
            osd_addr_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_tag_q    <= TAG_GBWR;
            grant_q      <= '0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            line_q       <= line_d;
            line_off_q   <= line_off_d;
            wr_bank_q    <= wr_bank_d;
            vsync_q      <= hVsync;
            overrun_q    <= overrun_d;
            wr_addr_q    <= wr_addr_d;
            blend_addr_q <= blend_addr_d;
            osd_addr_q   <= osd_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_tag_q    <= cmd_tag_d;
            grant_q      <= grant_d;
            stale_q      <= stale_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_write   = cmd_write_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_tag     = cmd_tag_q;
    assign cmd_len     = LEN;
    assign wr_bank     = wr_bank_q;
    assign busy        = (state_q != StIdle);
    assign overrun_cnt = overrun_q;

`ifdef VID_SCHED_STATS_EN
    logic [19:0] busy_cnt_q, busy_cycles_q;
    logic [7:0]  wait_q, max_wait_q;

    always_ff @(posedge hClk or posedge reset) begin
        if (reset) begin
            busy_cnt_q    <= '0;
            busy_cycles_q <= '0;
            wait_q        <= '0;
            max_wait_q    <= '0;
        end else begin
            if (frame_start) begin
                busy_cycles_q <= busy_cnt_q;
                busy_cnt_q    <= '0;
                max_wait_q    <= '0;
            end else begin
                if (busy && busy_cnt_q != 20'hFFFFF) begin
                    busy_cnt_q <= busy_cnt_q + 20'd1;
                end
                if (hs && wait_q > max_wait_q) begin
                    max_wait_q <= wait_q;
                end
            end
            if (state_q != StIssue) begin
                wait_q <= '0;
            end else if (wait_q != 8'hFF) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    assign busy_cycles = busy_cycles_q;
    assign max_wait    = max_wait_q;
`endif

endmodule

// File: tb/tb_vid_fb_burst_sched.sv
// Self-checking bench for vid_fb_burst_sched: event table plus hand-written stall, overrun,
// last-line and coincident frame-start sequences, with a command scoreboard.
module tb_vid_fb_burst_sched;

    localparam logic [22:0] B0  = 23'h10000;
    localparam logic [22:0] B1  = 23'h40000;
    localparam logic [22:0] OSD = 23'h70000;
    localparam int          STR = 320;
    localparam int          NL  = 144;

    logic        hClk = 1'b0;
    logic        reset = 1'b1;
    logic        hGBNewLine = 1'b0, hVsync = 1'b0, blend_en = 1'b0, osd_en = 1'b0;
    logic        cmd_ready = 1'b0, cmd_done = 1'b0;
    logic        cmd_valid, cmd_write, wr_bank, busy;
    logic [22:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [1:0]  cmd_tag;
    logic [7:0]  overrun_cnt;
`ifdef VID_SCHED_STATS_EN
    logic [19:0] busy_cycles;
    logic [7:0]  max_wait;
`endif

    vid_fb_burst_sched dut (
        .hClk        (hClk),
        .reset       (reset),
        .hGBNewLine  (hGBNewLine),
        .hVsync      (hVsync),
        .blend_en    (blend_en),
        .osd_en      (osd_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_tag     (cmd_tag),
        .cmd_done    (cmd_done),
        .wr_bank     (wr_bank),
        .busy        (busy),
`ifdef VID_SCHED_STATS_EN
        .busy_cycles (busy_cycles),
        .max_wait    (max_wait),
`endif
        .overrun_cnt (overrun_cnt)
    );

    always #5 hClk = ~hClk;

    typedef struct packed {
        logic        write;
        logic [22:0] addr;
        logic [1:0]  tag;
    } exp_t;

    typedef struct {
        logic        is_frame;
        logic        blend;
        logic        osd;
        int          exp_cmds;
        logic        exp_bank;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0, m_line = 0;
    logic m_bank = 1'b0, nl_next = 1'b0, vs_next = 1'b0, auto_ready = 1'b1, auto_done = 1'b1;

    function automatic logic [22:0] base(input logic b);
        return b ? B1 : B0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_cmd();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd got w=%0d addr=%h tag=%0d exp=none",
                     cmd_write, cmd_addr, cmd_tag);
        end else begin
            e = exp_q.pop_front();
            if ({cmd_write, cmd_addr, cmd_tag} !== e || cmd_len !== 9'd160) begin
                errors++;
                $display("FAIL cmd got w=%0d addr=%h tag=%0d len=%0d exp w=%0d addr=%h tag=%0d len=160",
                         cmd_write, cmd_addr, cmd_tag, cmd_len, e.write, e.addr, e.tag);
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, then score any handshake due at the next rise.
    task automatic step();
        @(negedge hClk);
        hGBNewLine = nl_next;
        nl_next    = 1'b0;
        hVsync     = vs_next;
        cmd_done   = 1'b0;
        if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) cmd_done = 1'b1;
        end
        if (auto_ready) cmd_ready = 1'b1;
        if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            if (auto_done) done_cnt = 3;
            check_cmd();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame_model();
        m_bank = ~m_bank;
        m_line = 0;
        if (blend_en) exp_q.push_back('{write: 1'b0, addr: base(~m_bank), tag: 2'd1});
        if (osd_en)   exp_q.push_back('{write: 1'b0, addr: OSD, tag: 2'd2});
    endtask

    task automatic newline_model();
        if (m_line < NL) begin
            exp_q.push_back('{write: 1'b1, addr: base(m_bank) + 23'(m_line * STR), tag: 2'd0});
            if (m_line + 1 < NL) begin
                if (blend_en)
                    exp_q.push_back('{write: 1'b0, addr: base(~m_bank) + 23'((m_line + 1) * STR),
                                      tag: 2'd1});
                if (osd_en)
                    exp_q.push_back('{write: 1'b0, addr: OSD + 23'((m_line + 1) * STR), tag: 2'd2});
            end
            m_line++;
        end
    endtask

    task automatic frame_pulse();
        vs_next = 1'b1;
        step();
        step();
        vs_next = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        exp_t front;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 3, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 2, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 3, 1'b0};

        run(3);
        @(negedge hClk);
        reset = 1'b0;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_write", 32'(cmd_write), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_cmd_len", 32'(cmd_len), 32'd160);
        check("rst_cmd_tag", 32'(cmd_tag), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);

        for (int v = 0; v < 8; v++) begin
            blend_en = vecs[v].blend;
            osd_en   = vecs[v].osd;
            hs_cnt   = 0;
            if (vecs[v].is_frame) begin
                frame_model();
                frame_pulse();
            end else begin
                newline_model();
                nl_next = 1'b1;
            end
            run(30);
            check($sformatf("vec%0d_cmds", v), 32'(hs_cnt), 32'(vecs[v].exp_cmds));
            check($sformatf("vec%0d_bank", v), 32'(wr_bank), 32'(vecs[v].exp_bank));
            check($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'd0);
        end

        // Ready withheld: command must hold steady and go out exactly once.
        blend_en   = 1'b0;
        osd_en     = 1'b0;
        auto_ready = 1'b0;
        cmd_ready  = 1'b0;
        hs_cnt     = 0;
        newline_model();
        front   = exp_q[0];
        nl_next = 1'b1;
        bad     = 0;
        for (int i = 0; i < 10 && !cmd_valid; i++) step();
        check("stall_valid_rise", 32'(cmd_valid), 32'd1);
        for (int i = 0; i < 50; i++) begin
            step();
            if (!cmd_valid || {cmd_write, cmd_addr, cmd_tag} !== front) bad++;
        end
        check("stall_stable", 32'(bad), 32'd0);
        auto_ready = 1'b1;
        run(30);
        check("stall_one_hs", 32'(hs_cnt), 32'd1);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Done withheld: next line finds the blend job still pending.
        blend_en  = 1'b1;
        auto_done = 1'b0;
        hs_cnt    = 0;
        newline_model();
        nl_next = 1'b1;
        run(30);
        check("ovr_first_hs", 32'(hs_cnt), 32'd1);
        check("ovr_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        newline_model();
        nl_next = 1'b1;
        step();
        step();
        check("ovr_count", 32'(overrun_cnt), 32'd1);
        hs_cnt    = 0;
        auto_done = 1'b1;
        done_cnt  = 1;
        run(30);
        check("ovr_after_hs", 32'(hs_cnt), 32'd2);
        check("ovr_drained", 32'(exp_q.size()), 32'd0);

        // Walk to the last visible line.
        blend_en = 1'b0;
        while (m_line < NL - 1) begin
            newline_model();
            nl_next = 1'b1;
            run(14);
        end
        check("walk_drained", 32'(exp_q.size()), 32'd0);
        check("walk_overrun", 32'(overrun_cnt), 32'd1);
        blend_en = 1'b1;
        osd_en   = 1'b1;
        hs_cnt   = 0;
        newline_model();
        nl_next = 1'b1;
        run(30);
        check("last_line_hs", 32'(hs_cnt), 32'd1);
        check("last_line_drained", 32'(exp_q.size()), 32'd0);
        hs_cnt = 0;
        newline_model();
        nl_next = 1'b1;
        run(30);
        check("past_end_hs", 32'(hs_cnt), 32'd0);
        check("past_end_busy", 32'(busy), 32'd0);

        // Frame start and line pulse together: only prefetches, line restarts at 0.
        hs_cnt = 0;
        frame_model();
        nl_next = 1'b1;
        frame_pulse();
        run(30);
        check("fs_nl_hs", 32'(hs_cnt), 32'd2);
        check("fs_nl_drained", 32'(exp_q.size()), 32'd0);
        check("fs_nl_bank", 32'(wr_bank), 32'(m_bank));
        hs_cnt = 0;
        newline_model();
        nl_next = 1'b1;
        run(30);
        check("fs_line0_hs", 32'(hs_cnt), 32'd3);
        check("fs_line0_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
